// File: rtl/taus_pkg.sv
// Shared types and constants for the taus88 seed loader.
// Seed lower bounds, seed count and loader state encoding.
package taus_pkg;

  localparam int SEED_W    = 32;
  localparam int NUM_SEEDS = 6;

  localparam logic [SEED_W-1:0] TAUS_MIN_S1 = 32'd2;
  localparam logic [SEED_W-1:0] TAUS_MIN_S2 = 32'd8;
  localparam logic [SEED_W-1:0] TAUS_MIN_S3 = 32'd16;

  typedef enum logic [1:0] {
    LOAD,
    HOLD,
    RUN
  } state_t;

endpackage

// File: rtl/taus_seed_loader_if.sv
// Seed word handshake between a seed source and the loader.
// master: seed_data/seed_valid out; slave: ready/idx/err out.
interface taus_seed_if;
  import taus_pkg::*;

  logic [SEED_W-1:0] seed_data;
  logic              seed_valid;
  logic              seed_ready;
  logic [2:0]        seed_idx;
  logic              seed_err;

  modport master (
    output seed_data,
    output seed_valid,
    input  seed_ready,
    input  seed_idx,
    input  seed_err
  );

  modport slave (
    input  seed_data,
    input  seed_valid,
    output seed_ready,
    output seed_idx,
    output seed_err
  );

endinterface

// File: rtl/taus_seed_check.sv
// Combinational taus88 lower-bound check for one seed word.
// Ports: idx (0..5), word -> legal (word >= minimum for idx mod 3).
module taus_seed_check
  import taus_pkg::*;
(
  input  logic [2:0]        idx,
  input  logic [SEED_W-1:0] word,
  output logic              legal
);

  logic [2:0]        sel;
  logic [SEED_W-1:0] min_v;

  // Seeds 4..6 reuse the bounds of seeds 1..3.
  assign sel = (idx >= 3'd3) ? idx - 3'd3 : idx;

  always_comb begin
    min_v = TAUS_MIN_S3;
    unique case (1'b1)
      (sel == 3'd0): min_v = TAUS_MIN_S1;
      (sel == 3'd1): min_v = TAUS_MIN_S2;
      default:       min_v = TAUS_MIN_S3;
    endcase
  end

  assign legal = (word >= min_v);

endmodule

// File: rtl/taus_seed_loader.sv
// Loads six checked taus88 seeds and releases the URNG pair.
// Ports: clk, reset, reload, sif (slave), urng_seed1..6, gen_reset, seeds_loaded.
module taus_seed_loader
  import taus_pkg::*;
#(
  parameter int                HOLD_CYCLES = 2,
  parameter logic [SEED_W-1:0] DEF_SEED1   = 32'h0000_1234,
  parameter logic [SEED_W-1:0] DEF_SEED2   = 32'h0000_5678,
  parameter logic [SEED_W-1:0] DEF_SEED3   = 32'h0000_9ABC
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              reload,
  taus_seed_if.slave        sif,
  output logic [SEED_W-1:0] urng_seed1,
  output logic [SEED_W-1:0] urng_seed2,
  output logic [SEED_W-1:0] urng_seed3,
  output logic [SEED_W-1:0] urng_seed4,
  output logic [SEED_W-1:0] urng_seed5,
  output logic [SEED_W-1:0] urng_seed6,
  output logic              gen_reset,
  output logic              seeds_loaded
);

  localparam logic [2:0] LAST_IDX = 3'(NUM_SEEDS - 1);
  localparam logic [3:0] HOLD_INI = 4'(HOLD_CYCLES - 1);

  state_t                          state_q;
  logic [2:0]                      idx_q;
  logic [3:0]                      cnt_q;
  logic                            err_q;
  logic                            gen_rst_q;
  logic                            loaded_q;
  logic [NUM_SEEDS-1:0][SEED_W-1:0] seed_q;
  logic                            legal;

  taus_seed_check u_check (
    .idx   (idx_q),
    .word  (sif.seed_data),
    .legal (legal)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= LOAD;
      idx_q     <= 3'd0;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      gen_rst_q <= 1'b1;
      loaded_q  <= 1'b0;
      seed_q[0] <= DEF_SEED1;
      seed_q[1] <= DEF_SEED2;
      seed_q[2] <= DEF_SEED3;
      seed_q[3] <= DEF_SEED1;
      seed_q[4] <= DEF_SEED2;
      seed_q[5] <= DEF_SEED3;
    end else if (reload) begin
      // Any pending word is dropped without an error.
      state_q   <= LOAD;
      idx_q     <= 3'd0;
      cnt_q     <= 4'd0;
      err_q     <= 1'b0;
      gen_rst_q <= 1'b1;
      loaded_q  <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (sif.seed_valid) begin
            if (!legal) begin
              err_q <= 1'b1;
            end else begin
              seed_q[idx_q] <= sif.seed_data;
              if (idx_q == LAST_IDX) begin
                state_q <= HOLD;
                cnt_q   <= HOLD_INI;
                idx_q   <= 3'd0;
              end else begin
                idx_q <= idx_q + 3'd1;
              end
            end
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            state_q   <= RUN;
            gen_rst_q <= 1'b0;
            loaded_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RUN: begin
        end
        default: begin
          state_q <= LOAD;
        end
      endcase
    end
  end

  assign sif.seed_ready = (state_q == LOAD);
  assign sif.seed_idx   = idx_q;
  assign sif.seed_err   = err_q;

  assign urng_seed1   = seed_q[0];
  assign urng_seed2   = seed_q[1];
  assign urng_seed3   = seed_q[2];
  assign urng_seed4   = seed_q[3];
  assign urng_seed5   = seed_q[4];
  assign urng_seed6   = seed_q[5];
  assign gen_reset    = gen_rst_q;
  assign seeds_loaded = loaded_q;

endmodule

// File: tb/tb_taus_seed_loader.sv
// Self-checking bench for taus_seed_loader.
// Event-level reference model plus directed literal checks.
module tb_taus_seed_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reload = 1'b0;
  logic [31:0] s1, s2, s3, s4, s5, s6;
  logic        gen_reset;
  logic        seeds_loaded;

  int n_chk  = 0;
  int n_fail = 0;

  taus_seed_if sif ();

  taus_seed_loader #(.HOLD_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .reload       (reload),
    .sif          (sif.slave),
    .urng_seed1   (s1),
    .urng_seed2   (s2),
    .urng_seed3   (s3),
    .urng_seed4   (s4),
    .urng_seed5   (s5),
    .urng_seed6   (s6),
    .gen_reset    (gen_reset),
    .seeds_loaded (seeds_loaded)
  );

  always #5 clk = ~clk;

  // Reference model: tracks loading progress and remaining hold time.
  logic [31:0] mins [6] = '{32'd2, 32'd8, 32'd16,
                            32'd2, 32'd8, 32'd16};
  logic [31:0] m_seed [6];
  int          m_idx = 0;
  bit          m_loading = 1'b1;
  int          m_hold = 0;
  bit          m_run = 1'b0;
  bit          m_err = 1'b0;
  bit          m_ok = 1'b0;

  always @(posedge clk) begin : model
    logic [31:0] s [6];
    int  idx, hold;
    bit  ld, run, err;
    s = m_seed; idx = m_idx; hold = m_hold;
    ld = m_loading; run = m_run; err = 1'b0;
    if (reset) begin
      s = '{32'h1234, 32'h5678, 32'h9ABC,
            32'h1234, 32'h5678, 32'h9ABC};
      idx = 0; hold = 0; ld = 1'b1; run = 1'b0;
    end else if (reload) begin
      idx = 0; hold = 0; ld = 1'b1; run = 1'b0;
    end else if (ld) begin
      if (sif.seed_valid) begin
        if (sif.seed_data < mins[idx]) begin
          err = 1'b1;
        end else begin
          s[idx] = sif.seed_data;
          if (idx == 5) begin
            idx = 0; ld = 1'b0; hold = 2;
          end else begin
            idx++;
          end
        end
      end
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) run = 1'b1;
    end
    m_seed    <= s;
    m_idx     <= idx;
    m_hold    <= hold;
    m_loading <= ld;
    m_run     <= run;
    m_err     <= err;
    if (reset) m_ok <= 1'b1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_ok) begin
      chk("m_ready", 32'(sif.seed_ready), 32'(m_loading));
      chk("m_idx", 32'(sif.seed_idx), 32'(m_idx));
      chk("m_err", 32'(sif.seed_err), 32'(m_err));
      chk("m_genrst", 32'(gen_reset), 32'(!m_run));
      chk("m_loaded", 32'(seeds_loaded), 32'(m_run));
      chk("m_s1", s1, m_seed[0]);
      chk("m_s2", s2, m_seed[1]);
      chk("m_s3", s3, m_seed[2]);
      chk("m_s4", s4, m_seed[3]);
      chk("m_s5", s5, m_seed[4]);
      chk("m_s6", s6, m_seed[5]);
    end
  end

  task automatic offer(input logic [31:0] w);
    @(negedge clk);
    sif.seed_valid = 1'b1;
    sif.seed_data  = w;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sif.seed_valid = 1'b0;
      reload = 1'b0;
      reset  = 1'b0;
    end
  endtask

  task automatic check_defaults(input string tag);
    chk({tag, "_s1"}, s1, 32'h1234);
    chk({tag, "_s2"}, s2, 32'h5678);
    chk({tag, "_s3"}, s3, 32'h9ABC);
    chk({tag, "_s6"}, s6, 32'h9ABC);
    chk({tag, "_gr"}, 32'(gen_reset), 32'd1);
    chk({tag, "_ld"}, 32'(seeds_loaded), 32'd0);
    chk({tag, "_idx"}, 32'(sif.seed_idx), 32'd0);
    chk({tag, "_rdy"}, 32'(sif.seed_ready), 32'd1);
  endtask

  initial begin
    sif.seed_valid = 1'b0;
    sif.seed_data  = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(10);
    check_defaults("rst");

    // Back-to-back legal load.
    for (int i = 0; i < 6; i++) offer(32'hA0 + 32'(i));
    idle(1);
    chk("hold1_gr", 32'(gen_reset), 32'd1);
    idle(1);
    chk("hold2_gr", 32'(gen_reset), 32'd1);
    idle(1);
    chk("run_gr", 32'(gen_reset), 32'd0);
    chk("run_ld", 32'(seeds_loaded), 32'd1);
    chk("ld_s1", s1, 32'hA0);
    chk("ld_s4", s4, 32'hA3);
    chk("ld_s6", s6, 32'hA5);

    // Words offered in RUN are ignored.
    offer(32'd1);
    idle(1);
    chk("run_noerr", 32'(sif.seed_err), 32'd0);
    chk("run_s1", s1, 32'hA0);

    // Reload from RUN.
    @(negedge clk);
    reload = 1'b1;
    idle(1);
    chk("rl_gr", 32'(gen_reset), 32'd1);
    chk("rl_ld", 32'(seeds_loaded), 32'd0);
    chk("rl_idx", 32'(sif.seed_idx), 32'd0);
    chk("rl_rdy", 32'(sif.seed_ready), 32'd1);
    chk("rl_old", s1, 32'hA0);

    // Rejection at idx 2, then the exact minimum.
    offer(32'd100);
    offer(32'd200);
    offer(32'd15);
    offer(32'd16);
    chk("rej_err", 32'(sif.seed_err), 32'd1);
    chk("rej_idx", 32'(sif.seed_idx), 32'd2);
    chk("rej_s3", s3, 32'hA2);
    idle(1);
    chk("acc_err", 32'(sif.seed_err), 32'd0);
    chk("acc_idx", 32'(sif.seed_idx), 32'd3);
    chk("acc_s3", s3, 32'd16);

    // Boundaries for seeds 4..6, one reject at idx 4.
    offer(32'd2);
    offer(32'd7);
    offer(32'd8);
    offer(32'd16);
    idle(5);
    chk("b_s4", s4, 32'd2);
    chk("b_s5", s5, 32'd8);
    chk("b_ld", 32'(seeds_loaded), 32'd1);

    // Reload wins over a word offered in the same cycle.
    @(negedge clk);
    reload = 1'b1;
    idle(1);
    offer(32'h300);
    offer(32'hFF);
    reload = 1'b1;
    idle(1);
    chk("rv_idx", 32'(sif.seed_idx), 32'd0);
    chk("rv_s2", s2, 32'd200);
    chk("rv_err", 32'(sif.seed_err), 32'd0);

    // Reset during HOLD.
    for (int i = 0; i < 6; i++) offer(32'h40 + 32'(i));
    @(negedge clk);
    sif.seed_valid = 1'b0;
    chk("h_gr", 32'(gen_reset), 32'd1);
    reset = 1'b1;
    idle(1);
    check_defaults("rh");

    // Reset after three seeds.
    for (int i = 0; i < 3; i++) offer(32'h50 + 32'(i));
    @(negedge clk);
    sif.seed_valid = 1'b0;
    chk("p_s3", s3, 32'h52);
    reset = 1'b1;
    idle(1);
    check_defaults("rp");
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
